// File: rtl/nou_pkg.sv
// nou_pkg: shared widths, error codes, buffer unit size and allocator states
package nou_pkg;
  localparam int NOU_PKT_HEADER_SZ_WIDTH   = 16;
  localparam int NOU_PKT_DATA_SZ_WIDTH     = 16;
  localparam int NOU_PKT_HEADER_ADDR_WIDTH = 32;
  localparam int NOU_PKT_DATA_ADDR_WIDTH   = 32;
  localparam int NOU_ERR_CODE_WIDTH        = 2;
  localparam int NOU_BUF_UNIT_BYTES        = 64;
  localparam logic [NOU_ERR_CODE_WIDTH-1:0] ERR_NONE      = 2'd0;
  localparam logic [NOU_ERR_CODE_WIDTH-1:0] ERR_HDR_FULL  = 2'd1;
  localparam logic [NOU_ERR_CODE_WIDTH-1:0] ERR_DATA_FULL = 2'd2;
  localparam logic [NOU_ERR_CODE_WIDTH-1:0] ERR_SIZE      = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_GRANT} nou_buf_state_e;
endpackage

// File: rtl/nou_buf_region.sv
// nou_buf_region: one circular region (head/used, free count, commit/release, saturation, peak); NOU_BUF_ALLOC_STATS_EN adds the peak-used port
module nou_buf_region
  import nou_pkg::*;
#(
  parameter int CAP_LOG2 = 4,
  parameter int SZ_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SZ_W-1:0]            req_bytes_i,
  input  logic                       commit_i,
  input  logic                       rel_vld_i,
  input  logic [SZ_W-1:0]            rel_bytes_i,
  output logic [SZ_W-$clog2(NOU_BUF_UNIT_BYTES):0] req_units_o,
  output logic [CAP_LOG2-1:0]        head_o,
  output logic [CAP_LOG2:0]          free_o,
  output logic                       rel_err_o
`ifdef NOU_BUF_ALLOC_STATS_EN
  ,
  output logic [CAP_LOG2:0]          hwm_o
`endif
);
  localparam int US = $clog2(NOU_BUF_UNIT_BYTES);
  localparam int UW = SZ_W + 1 - US;
  localparam int CW = CAP_LOG2 + 1;
  logic [SZ_W:0] req_sum, rel_sum;
  logic [UW-1:0] rel_units;
  logic [CAP_LOG2-1:0] head_q, head_d;
  logic [CW-1:0] used_q, used_d, used_rel;
  logic rel_over, rel_err_q, rel_err_d;
  // units = ceil(bytes/64) one bit wider than the size; release saturates before the commit is added
  always_comb begin
    req_sum     = {1'b0, req_bytes_i} + (SZ_W+1)'(NOU_BUF_UNIT_BYTES - 1);
    rel_sum     = {1'b0, rel_bytes_i} + (SZ_W+1)'(NOU_BUF_UNIT_BYTES - 1);
    req_units_o = req_sum[SZ_W:US];
    rel_units   = rel_sum[SZ_W:US];
    rel_over    = rel_vld_i && (rel_units > UW'(used_q));
    used_rel    = !rel_vld_i ? used_q : rel_over ? '0 : used_q - CW'(rel_units);
    used_d      = used_rel + (commit_i ? CW'(req_units_o) : '0);
    head_d      = commit_i ? head_q + CAP_LOG2'(req_units_o) : head_q;
    rel_err_d   = rel_err_q | rel_over;
    free_o      = CW'(1 << CAP_LOG2) - used_q;
    head_o      = head_q;
    rel_err_o   = rel_err_q;
  end
  // region state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q    <= '0;
      used_q    <= '0;
      rel_err_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      used_q    <= used_d;
      rel_err_q <= rel_err_d;
    end
  end
`ifdef NOU_BUF_ALLOC_STATS_EN
  logic [CW-1:0] hwm_q;
  // peak used units, sampled on commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hwm_q <= '0;
    else if (commit_i && used_d > hwm_q) hwm_q <= used_d;
  end
  assign hwm_o = hwm_q;
`endif
endmodule

// File: rtl/nou_buf_alloc.sv
// nou_buf_alloc: header/data receive-buffer allocator; NOU_BUF_ALLOC_STATS_EN adds grant/reject counters and peak-used ports
module nou_buf_alloc
  import nou_pkg::*;
#(
  parameter logic [NOU_PKT_HEADER_ADDR_WIDTH-1:0] HDR_BASE  = 32'h1000_0000,
  parameter logic [NOU_PKT_DATA_ADDR_WIDTH-1:0]   DATA_BASE = 32'h2000_0000,
  parameter int HDR_CAP_LOG2  = 4,
  parameter int DATA_CAP_LOG2 = 6
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_buf_vld,
  input  logic [NOU_PKT_HEADER_SZ_WIDTH-1:0]   req_buf_header_size,
  input  logic [NOU_PKT_DATA_SZ_WIDTH-1:0]     req_buf_data_size,
  output logic                                 gnt_buf_vld,
  output logic                                 gnt_buf_status,
  output logic [NOU_PKT_HEADER_ADDR_WIDTH-1:0] header_buf_addr,
  output logic [NOU_PKT_DATA_ADDR_WIDTH-1:0]   data_buf_addr,
  output logic [NOU_ERR_CODE_WIDTH-1:0]        err_code,
  input  logic                                 rel_vld,
  input  logic [NOU_PKT_HEADER_SZ_WIDTH-1:0]   rel_header_size,
  input  logic [NOU_PKT_DATA_SZ_WIDTH-1:0]     rel_data_size,
  output logic [HDR_CAP_LOG2:0]                hdr_free_units,
  output logic [DATA_CAP_LOG2:0]               data_free_units,
  output logic                                 rel_err
`ifdef NOU_BUF_ALLOC_STATS_EN
  ,
  output logic [31:0]                          stat_grant_cnt,
  output logic [31:0]                          stat_reject_cnt,
  output logic [HDR_CAP_LOG2:0]                stat_hdr_hwm,
  output logic [DATA_CAP_LOG2:0]               stat_data_hwm
`endif
);
  localparam int US   = $clog2(NOU_BUF_UNIT_BYTES);
  localparam int HUW  = NOU_PKT_HEADER_SZ_WIDTH + 1 - US;
  localparam int DUW  = NOU_PKT_DATA_SZ_WIDTH + 1 - US;
  localparam int HCAP = 1 << HDR_CAP_LOG2;
  localparam int DCAP = 1 << DATA_CAP_LOG2;
  nou_buf_state_e state_q, state_d;
  logic [NOU_PKT_HEADER_SZ_WIDTH-1:0] hdr_sz_q;
  logic [NOU_PKT_DATA_SZ_WIDTH-1:0] data_sz_q;
  logic [HUW-1:0] hdr_units;
  logic [DUW-1:0] data_units;
  logic [HDR_CAP_LOG2-1:0] hdr_head;
  logic [DATA_CAP_LOG2-1:0] data_head;
  logic hdr_rel_err, data_rel_err, commit, status_q;
  logic [NOU_ERR_CODE_WIDTH-1:0] err_d, err_q;
  logic [NOU_PKT_HEADER_ADDR_WIDTH-1:0] hdr_addr_q;
  logic [NOU_PKT_DATA_ADDR_WIDTH-1:0] data_addr_q;
  nou_buf_region #(.CAP_LOG2(HDR_CAP_LOG2), .SZ_W(NOU_PKT_HEADER_SZ_WIDTH)) u_hdr (
    .clk(clk), .rst(rst), .req_bytes_i(hdr_sz_q), .commit_i(commit),
    .rel_vld_i(rel_vld), .rel_bytes_i(rel_header_size), .req_units_o(hdr_units),
    .head_o(hdr_head), .free_o(hdr_free_units), .rel_err_o(hdr_rel_err)
`ifdef NOU_BUF_ALLOC_STATS_EN
    , .hwm_o(stat_hdr_hwm)
`endif
  );
  nou_buf_region #(.CAP_LOG2(DATA_CAP_LOG2), .SZ_W(NOU_PKT_DATA_SZ_WIDTH)) u_data (
    .clk(clk), .rst(rst), .req_bytes_i(data_sz_q), .commit_i(commit),
    .rel_vld_i(rel_vld), .rel_bytes_i(rel_data_size), .req_units_o(data_units),
    .head_o(data_head), .free_o(data_free_units), .rel_err_o(data_rel_err)
`ifdef NOU_BUF_ALLOC_STATS_EN
    , .hwm_o(stat_data_hwm)
`endif
  );
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else state_q <= state_d;
  end
  // next state: request starts a fixed IDLE -> CALC -> GRANT -> IDLE sequence
  always_comb begin
    state_d = state_q == ST_IDLE  ? (req_buf_vld ? ST_CALC : ST_IDLE) :
              state_q == ST_CALC  ? ST_GRANT : ST_IDLE;
  end
  // outputs: grant pulse in GRANT, commit only for accepted grants; size check precedes fullness checks
  always_comb begin
    gnt_buf_vld     = state_q == ST_GRANT;
    commit          = gnt_buf_vld && status_q;
    err_d           = (hdr_units == '0 || hdr_units > HUW'(HCAP) || data_units > DUW'(DCAP)) ? ERR_SIZE :
                      hdr_units > HUW'(hdr_free_units)   ? ERR_HDR_FULL :
                      data_units > DUW'(data_free_units) ? ERR_DATA_FULL : ERR_NONE;
    gnt_buf_status  = status_q;
    err_code        = err_q;
    header_buf_addr = hdr_addr_q;
    data_buf_addr   = data_addr_q;
    rel_err         = hdr_rel_err | data_rel_err;
  end
  // latch sizes on request and the grant result in CALC; heads cannot move between CALC and GRANT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_sz_q    <= '0;
      data_sz_q   <= '0;
      status_q    <= 1'b0;
      err_q       <= ERR_NONE;
      hdr_addr_q  <= HDR_BASE;
      data_addr_q <= DATA_BASE;
    end else if (state_q == ST_IDLE && req_buf_vld) begin
      hdr_sz_q  <= req_buf_header_size;
      data_sz_q <= req_buf_data_size;
    end else if (state_q == ST_CALC) begin
      status_q    <= err_d == ERR_NONE;
      err_q       <= err_d;
      hdr_addr_q  <= HDR_BASE + (NOU_PKT_HEADER_ADDR_WIDTH'(hdr_head) << US);
      data_addr_q <= DATA_BASE + (NOU_PKT_DATA_ADDR_WIDTH'(data_head) << US);
    end
  end
`ifdef NOU_BUF_ALLOC_STATS_EN
  logic [31:0] grant_cnt_q, reject_cnt_q;
  // grant/reject counters, wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt_q  <= '0;
      reject_cnt_q <= '0;
    end else if (gnt_buf_vld) begin
      grant_cnt_q  <= grant_cnt_q + {31'd0, status_q};
      reject_cnt_q <= reject_cnt_q + {31'd0, !status_q};
    end
  end
  assign stat_grant_cnt  = grant_cnt_q;
  assign stat_reject_cnt = reject_cnt_q;
`endif
endmodule

// File: doc/nou_buf_alloc.md
# nou_buf_alloc

Receive-buffer allocator for the NOU inbound path. It sits directly downstream of the receive packet unit's buffer request port (`req_buf_*`) and returns `gnt_buf_*` with a header address and a data address. It manages two circular regions in local memory, one for headers and one for data, in 64-byte units. Space is released in order by the retire unit once software has consumed a packet.

## Interface
Parameters:
- `HDR_BASE`, default `32'h1000_0000`: byte base address of the header region.
- `DATA_BASE`, default `32'h2000_0000`: byte base address of the data region.
- `HDR_CAP_LOG2`, default 4: header region capacity is 2^N units.
- `DATA_CAP_LOG2`, default 6: data region capacity is 2^N units.

Ports:
- `clk` in, 1: clock.
- `rst` in, 1: reset. One clock; reset is asynchronous and active-high.
- `req_buf_vld` in, 1: single-cycle allocation request pulse.
- `req_buf_header_size` in, `NOU_PKT_HEADER_SZ_WIDTH`: header size in bytes.
- `req_buf_data_size` in, `NOU_PKT_DATA_SZ_WIDTH`: data size in bytes.
- `gnt_buf_vld` out, 1: single-cycle grant pulse.
- `gnt_buf_status` out, 1: 1 = allocated, 0 = rejected.
- `header_buf_addr` out, `NOU_PKT_HEADER_ADDR_WIDTH`: granted header byte address.
- `data_buf_addr` out, `NOU_PKT_DATA_ADDR_WIDTH`: granted data byte address.
- `err_code` out, `NOU_ERR_CODE_WIDTH`: reject reason.
- `rel_vld` in, 1: in-order release pulse from the retire unit.
- `rel_header_size` in, `NOU_PKT_HEADER_SZ_WIDTH`: released header bytes.
- `rel_data_size` in, `NOU_PKT_DATA_SZ_WIDTH`: released data bytes.
- `hdr_free_units` out, `HDR_CAP_LOG2+1`: free header units.
- `data_free_units` out, `DATA_CAP_LOG2+1`: free data units.
- `rel_err` out, 1: sticky; set when a release exceeds the used count.

## Operation
- Unit size: 64 bytes. `units = ceil(bytes/64)`, computed as `(bytes+63)>>6` at full width with no overflow.
- Per-region state: `head` (next allocation offset, in units, modulo capacity) and `used` (in units). Tail is implicit, because release is in order.
- State machine: IDLE, CALC, GRANT.
  - IDLE → CALC on `req_buf_vld`. Sizes are latched.
  - CALC: compute units, then check in priority order:
    - header units = 0, header units > header capacity, or data units > data capacity → `ERR_SIZE` (3).
    - header units > header free → `ERR_HDR_FULL` (1).
    - data units > data free → `ERR_DATA_FULL` (2).
    - otherwise → `ERR_NONE` (0).
  - CALC → GRANT always.
  - GRANT: drive the grant pulse. If status is 1, commit: each `head += units` (mod capacity) and each `used += units`. GRANT → IDLE.
- Addresses:
  - `header_buf_addr = HDR_BASE + head_hdr*64`.
  - `data_buf_addr = DATA_BASE + head_data*64`.
  - Both are driven from the pre-commit head values.
- Allocations may span the region end. Address wrap modulo the region is the writer's responsibility; this block guarantees only that enough units are available.
- Data size 0 is legal: `data_buf_addr` is the current data head and no data units are consumed.
- A rejected grant leaves all state unchanged, and the addresses are still driven.
- Release: on `rel_vld`, `used -= units` per region. If the units exceed `used`, `used` saturates to 0 and `rel_err` sets; it is cleared only by reset.
- A release and a commit in the same cycle are both applied: `used_next = used + alloc - rel`.
- A `req_buf_vld` arriving outside IDLE is ignored. Upstream guarantees one outstanding request.

## Timing
- `req_buf_vld` sampled in cycle 0 → `gnt_buf_vld` high in cycle 2, for exactly one cycle.
- `gnt_buf_status`, `err_code` and both addresses are valid only while `gnt_buf_vld` is high. They hold their last value otherwise.
- CALC compares against the registered free counts. A release in the CALC cycle is not visible to that check.
- Free counts update in the cycle after a commit or release.
- Reset values:
  - Outputs: `gnt_buf_vld`=0, `gnt_buf_status`=0, `err_code`=0, addresses = `HDR_BASE`/`DATA_BASE`, `rel_err`=0, free counts = full capacity.
  - Internal: state IDLE, heads 0, used 0.
- Reset mid-operation aborts any pending grant. No grant pulse is issued after reset deasserts.

## Configuration
- `NOU_BUF_ALLOC_STATS_EN` defined: adds output ports `stat_grant_cnt` (32b), `stat_reject_cnt` (32b), `stat_hdr_hwm` and `stat_data_hwm` (peak used units).
  - The counters wrap at 2^32.
  - The high-water marks update on commit.
  - All reset to 0.
- Undefined: those ports and their registers are absent. Behaviour is otherwise identical.

## Structure
- Shared `nou_pkg`:
  - Error code constants `ERR_NONE`, `ERR_HDR_FULL`, `ERR_DATA_FULL`, `ERR_SIZE`.
  - `NOU_BUF_UNIT_BYTES` = 64.
  - The state enum.
- One sub-module, `nou_buf_region`, instantiated twice. It holds `head`/`used`, the free computation, the commit/release update, saturation, and the high-water mark.

## Test plan
Defaults for all scenarios: header capacity 16 units, data capacity 64 units.
- After reset: request header 64, data 200 → status 1 in cycle 2, header address 0x1000_0000, data address 0x2000_0000. Then `hdr_free_units`=15, `data_free_units`=60.
- Second request header 100, data 64 → header address 0x1000_0040, data address 0x2000_0100. Free counts 13/59.
- Data 64×63 bytes with 60 data units free → status 0, `err_code`=2, heads unchanged. Header size 0 → `err_code`=3.
- Fill the header region to 15 used, release 1 unit in the same cycle as a 1-unit commit → used stays 15. Wrap: after head 15 with used 0, a 2-unit allocation gets address 0x1000_03C0 and head becomes 1.
- Release data 128 bytes with `used`=1 → `used`=0 and `rel_err`=1, held until reset.
- Assert `rst` in the CALC cycle → no grant pulse, all outputs at reset values, free counts full.
